game_timer: RTL and testbench

Parametrised run/hold timer ticked by the slow game clock. Counts up or down between 0 and a programmable `MAX_COUNT`, with start/stop/clear/load control. Either wraps with a terminal-count pulse or saturates into a sticky expired state. Drives the round timer and score display logic, and replaces the fixed 5-bit free-running counter in the game datapath.

---
 rtl/game_timer_pkg.sv | 9 +
 rtl/game_timer.sv | 102 ++++++++++
 tb/tb_game_timer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game round timer.
package game_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} timer_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/game_timer.sv
// Run/hold up/down timer on the slow game clock; wraps with a terminal-count
// pulse or saturates into a sticky DONE state depending on SATURATE.
import game_timer_pkg::*;

module game_timer #(
  parameter int WIDTH     = 5,
  parameter int MAX_COUNT = 31,
  parameter int SATURATE  = 0
) (
  input  logic             clk_4_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             tc_o,
  output logic             expired_o
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("game_timer: WIDTH must be in 1..16");
  end
  if (MAX_COUNT < 0 || MAX_COUNT >= (1 << WIDTH)) begin : g_bad_max
    $error("game_timer: MAX_COUNT must be below 2**WIDTH");
  end

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_COUNT);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             running_q, expired_q;
  logic [WIDTH:0]   next_ext;
  logic             terminal;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tc_d     = 1'b0;
    next_ext = '0;
    terminal = 1'b0;

    if (clear_i) begin
      count_d = '0;
      state_d = IDLE;
    end else if (load_i) begin
      count_d = ({1'b0, load_val_i} > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val_i;
      if (state_q == DONE) state_d = IDLE;
    end else if (stop_i) begin
      // Stop dominates start; only RUN reacts to it.
      if (state_q == RUN) state_d = HOLD;
    end else if (start_i && (state_q == IDLE || state_q == HOLD)) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      // One extra bit makes both overflow and borrow visible.
      if (dir_i == DIR_DOWN) begin
        next_ext = {1'b0, count_q} - 1'b1;
        terminal = next_ext[WIDTH];
      end else begin
        next_ext = {1'b0, count_q} + 1'b1;
        terminal = (next_ext > MAX_EXT);
      end

      if (!terminal) begin
        count_d = next_ext[WIDTH-1:0];
      end else begin
        tc_d = 1'b1;
        if (SATURATE != 0) begin
          state_d = DONE;
        end else begin
          count_d = (dir_i == DIR_DOWN) ? MAX_EXT[WIDTH-1:0] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      count_q   <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == DONE);
    end
  end

  assign count_o   = count_q;
  assign running_o = running_q;
  assign tc_o      = tc_q;
  assign expired_o = expired_q;

endmodule

// File: tb/tb_game_timer.sv
// Runs a wrap-mode and a saturate-mode timer side by side on shared stimulus
// and compares both against a behavioural model of the counting rules.
module tb_game_timer;

  localparam int W    = 5;
  localparam int MAXC = 9;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop, clear, load, dir;
  logic [W-1:0] load_val;

  logic [W-1:0] w_cnt, s_cnt;
  logic         w_run, w_tc, w_exp, s_run, s_tc, s_exp;

  int checks   = 0;
  int failures = 0;

  int m_cnt [2];
  int m_st  [2];
  bit m_tc  [2];

  always #5 clk = ~clk;

  game_timer #(.WIDTH(W), .MAX_COUNT(MAXC), .SATURATE(0)) u_wrap (
    .clk_4_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .clear_i(clear), .load_i(load), .load_val_i(load_val), .dir_i(dir),
    .count_o(w_cnt), .running_o(w_run), .tc_o(w_tc), .expired_o(w_exp)
  );

  game_timer #(.WIDTH(W), .MAX_COUNT(MAXC), .SATURATE(1)) u_sat (
    .clk_4_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .clear_i(clear), .load_i(load), .load_val_i(load_val), .dir_i(dir),
    .count_o(s_cnt), .running_o(s_run), .tc_o(s_tc), .expired_o(s_exp)
  );

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_st[i]  = M_IDLE;
      m_tc[i]  = 1'b0;
    end
  endfunction

  // Behavioural rules: target = count +/- 1; leaving [0, MAXC] is a terminal
  // event, resolved by modular wrap or by freezing in DONE.
  function automatic void model_edge();
    int target;
    for (int i = 0; i < 2; i++) begin
      m_tc[i] = 1'b0;
      if (clear) begin
        m_cnt[i] = 0;
        m_st[i]  = M_IDLE;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
        if (m_st[i] == M_DONE) m_st[i] = M_IDLE;
      end else if (stop) begin
        if (m_st[i] == M_RUN) m_st[i] = M_HOLD;
      end else if (start && (m_st[i] == M_IDLE || m_st[i] == M_HOLD)) begin
        m_st[i] = M_RUN;
      end else if (m_st[i] == M_RUN) begin
        target = dir ? m_cnt[i] - 1 : m_cnt[i] + 1;
        if (target >= 0 && target <= MAXC) begin
          m_cnt[i] = target;
        end else begin
          m_tc[i] = 1'b1;
          if (i == 1) m_st[i] = M_DONE;
          else        m_cnt[i] = (target + MAXC + 1) % (MAXC + 1);
        end
      end
    end
  endfunction

  function automatic logic [7:0] exp_pack(int i);
    return {W'(m_cnt[i]), m_st[i] == M_RUN, m_tc[i], m_st[i] == M_DONE};
  endfunction

  function automatic logic [7:0] obs_wrap();
    return {w_cnt, w_run, w_tc, w_exp};
  endfunction

  function automatic logic [7:0] obs_sat();
    return {s_cnt, s_run, s_tc, s_exp};
  endfunction

  task automatic set_in(bit st, bit sp, bit cl, bit ld, logic [W-1:0] lv, bit d);
    start = st; stop = sp; clear = cl; load = ld; load_val = lv; dir = d;
  endtask

  // One rising edge; model follows it; returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, '0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_wrap() !== 8'h00) begin
      failures++; $display("FAIL reset_wrap got=%h exp=%h", obs_wrap(), 8'h00);
    end
    checks++;
    if (obs_sat() !== 8'h00) begin
      failures++; $display("FAIL reset_sat got=%h exp=%h", obs_sat(), 8'h00);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs_wrap() !== exp_pack(0)) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", obs_wrap(), exp_pack(0));
    end
    $display("test_reset done");
  endtask

  task automatic test_wrap_up();
    set_in(0, 0, 1, 0, '0, 0); tick();
    set_in(1, 0, 0, 0, '0, 0); tick();
    set_in(0, 0, 0, 0, '0, 0);
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (obs_wrap() !== exp_pack(0)) begin
        failures++; $display("FAIL wrap_up cyc=%0d got=%h exp=%h", c, obs_wrap(), exp_pack(0));
      end
      // Tenth step is the wrap: count back to 0 with tc high.
      if (c == 9) begin
        checks++;
        if ({w_cnt, w_tc, w_exp} !== {5'd0, 1'b1, 1'b0}) begin
          failures++; $display("FAIL wrap_tc got cnt=%0d tc=%b exp_o=%b want 0/1/0", w_cnt, w_tc, w_exp);
        end
      end
      if (c == 10) begin
        checks++;
        if (w_tc !== 1'b0) begin
          failures++; $display("FAIL wrap_tc_width got=%b exp=0", w_tc);
        end
      end
    end
    $display("test_wrap_up done");
  endtask

  task automatic test_saturate_down();
    set_in(0, 0, 1, 0, '0, 1); tick();
    set_in(0, 0, 0, 1, 5'd3, 1); tick();
    set_in(1, 0, 0, 0, '0, 1); tick();
    set_in(0, 0, 0, 0, '0, 1);
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs_sat() !== exp_pack(1)) begin
        failures++; $display("FAIL sat_down cyc=%0d got=%h exp=%h", c, obs_sat(), exp_pack(1));
      end
    end
    checks++;
    if ({s_cnt, s_run, s_exp} !== {5'd0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL sat_done got cnt=%0d run=%b exp_o=%b want 0/0/1", s_cnt, s_run, s_exp);
    end
    set_in(1, 0, 0, 0, '0, 1); tick();
    checks++;
    if (obs_sat() !== exp_pack(1)) begin
      failures++; $display("FAIL sat_start_ignored got=%h exp=%h", obs_sat(), exp_pack(1));
    end
    set_in(0, 0, 0, 1, 5'd5, 1); tick();
    checks++;
    if ({s_cnt, s_run, s_exp} !== {5'd5, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sat_load_leave got=%h exp cnt=5 idle", obs_sat());
    end
    $display("test_saturate_down done");
  endtask

  task automatic test_pause();
    set_in(0, 0, 1, 0, '0, 0); tick();
    set_in(1, 0, 0, 0, '0, 0); tick();
    set_in(0, 0, 0, 0, '0, 0);
    repeat (4) tick();
    set_in(0, 1, 0, 0, '0, 0); tick();
    set_in(0, 0, 0, 0, '0, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({w_cnt, w_run} !== {5'd4, 1'b0} || obs_wrap() !== exp_pack(0)) begin
        failures++; $display("FAIL pause_hold cyc=%0d got=%h exp=%h", c, obs_wrap(), exp_pack(0));
      end
    end
    set_in(1, 0, 0, 0, '0, 0); tick();
    set_in(0, 0, 0, 0, '0, 0);
    checks++;
    if ({w_cnt, w_run} !== {5'd4, 1'b1}) begin
      failures++; $display("FAIL resume_run got=%h exp cnt=4 run=1", obs_wrap());
    end
    tick();
    checks++;
    if (w_cnt !== 5'd5) begin
      failures++; $display("FAIL resume_step got=%0d exp=5", w_cnt);
    end
    set_in(1, 1, 0, 0, '0, 0); tick();
    set_in(0, 0, 0, 0, '0, 0);
    checks++;
    if ({w_cnt, w_run} !== {5'd5, 1'b0} || obs_wrap() !== exp_pack(0)) begin
      failures++; $display("FAIL start_stop_together got=%h exp=%h", obs_wrap(), exp_pack(0));
    end
    $display("test_pause done");
  endtask

  task automatic test_load_clamp();
    set_in(0, 0, 0, 1, 5'd25, 0); tick();
    checks++;
    if (w_cnt !== 5'd9 || s_cnt !== 5'd9) begin
      failures++; $display("FAIL load_clamp got=%0d/%0d exp=9", w_cnt, s_cnt);
    end
    set_in(0, 0, 1, 1, 5'd6, 0); tick();
    checks++;
    if ({w_cnt, w_run, w_tc, w_exp} !== 8'h00) begin
      failures++; $display("FAIL clear_over_load got=%h exp=00", obs_wrap());
    end
    set_in(1, 0, 0, 0, '0, 0); tick();
    set_in(0, 0, 0, 0, '0, 0); tick(); tick();
    set_in(0, 0, 0, 1, 5'd7, 0); tick();
    checks++;
    if ({w_cnt, w_run} !== {5'd7, 1'b1} || obs_wrap() !== exp_pack(0)) begin
      failures++; $display("FAIL load_in_run got=%h exp=%h", obs_wrap(), exp_pack(0));
    end
    set_in(0, 0, 0, 0, '0, 0); tick();
    checks++;
    if (w_cnt !== 5'd8) begin
      failures++; $display("FAIL load_resume got=%0d exp=8", w_cnt);
    end
    $display("test_load_clamp done");
  endtask

  task automatic test_async_reset();
    set_in(0, 0, 1, 0, '0, 0); tick();
    set_in(1, 0, 0, 0, '0, 0); tick();
    set_in(0, 0, 0, 0, '0, 0);
    repeat (7) tick();
    checks++;
    if ({w_cnt, w_run} !== {5'd7, 1'b1}) begin
      failures++; $display("FAIL pre_reset got=%h exp cnt=7 run=1", obs_wrap());
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs_wrap() !== 8'h00 || obs_sat() !== 8'h00) begin
      failures++; $display("FAIL async_reset got=%h/%h exp=00", obs_wrap(), obs_sat());
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs_wrap() !== 8'h00) begin
        failures++; $display("FAIL post_reset_idle cyc=%0d got=%h exp=00", c, obs_wrap());
      end
    end
    set_in(1, 0, 0, 0, '0, 0); tick();
    set_in(0, 0, 0, 0, '0, 0); tick();
    checks++;
    if ({w_cnt, w_run} !== {5'd1, 1'b1}) begin
      failures++; $display("FAIL post_reset_start got=%h exp cnt=1 run=1", obs_wrap());
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      set_in($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 6,
             r < 3, (r >= 3 && r < 8), W'($urandom_range(0, 31)),
             $urandom_range(0, 99) < 40);
      tick();
      checks++;
      if (obs_wrap() !== exp_pack(0)) begin
        failures++; $display("FAIL rand_wrap cyc=%0d got=%h exp=%h", c, obs_wrap(), exp_pack(0));
      end
      checks++;
      if (obs_sat() !== exp_pack(1)) begin
        failures++; $display("FAIL rand_sat cyc=%0d got=%h exp=%h", c, obs_sat(), exp_pack(1));
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_saturate_down();
    test_pause();
    test_load_clamp();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
